// File: rtl/ttt_game_state_if.sv
// Board/turn status bundle between the input conditioning, the
// game-state engine and the VGA renderer.
interface ttt_game_state_if;
    logic [3:0]  square_sel;
    logic        place;
    logic        new_game;
    logic [17:0] board;
    logic        player_turn;
    logic        busy;
    logic        illegal;
    logic        game_over;
    logic [1:0]  winner;
    logic [2:0]  win_line;
    logic [3:0]  move_count;

    modport master (
        output square_sel, place, new_game,
        input  board, player_turn, busy, illegal, game_over, winner, win_line, move_count
    );

    modport slave (
        input  square_sel, place, new_game,
        output board, player_turn, busy, illegal, game_over, winner, win_line, move_count
    );
endinterface

// File: rtl/ttt_game_state.sv
// Tic-tac-toe game-state engine: holds the board, alternates turns, rejects
// illegal moves and scans one winning line per cycle after each placement.
module ttt_game_state (
    input  logic             clk,
    input  logic             rst_n,
    ttt_game_state_if.slave  bus
);
    localparam logic [1:0] ST_PLAY   = 2'd0;
    localparam logic [1:0] ST_CHECK  = 2'd1;
    localparam logic [1:0] ST_WIN    = 2'd2;
    localparam logic [1:0] ST_DRAW   = 2'd3;

    localparam logic [1:0] MARK_NONE = 2'b00;
    localparam logic [1:0] MARK_X    = 2'b01;
    localparam logic [1:0] MARK_O    = 2'b10;

    // Out-of-range indices read as empty so callers never index past the board.
    function automatic logic [1:0] cell_at(input logic [17:0] b, input logic [3:0] idx);
        case (idx)
            4'd0:    cell_at = b[1:0];
            4'd1:    cell_at = b[3:2];
            4'd2:    cell_at = b[5:4];
            4'd3:    cell_at = b[7:6];
            4'd4:    cell_at = b[9:8];
            4'd5:    cell_at = b[11:10];
            4'd6:    cell_at = b[13:12];
            4'd7:    cell_at = b[15:14];
            4'd8:    cell_at = b[17:16];
            default: cell_at = MARK_NONE;
        endcase
    endfunction

    // Three packed 4-bit cell indices for each of the eight winning lines.
    function automatic logic [11:0] line_cells(input logic [2:0] idx);
        case (idx)
            3'd0:    line_cells = {4'd0, 4'd1, 4'd2};
            3'd1:    line_cells = {4'd3, 4'd4, 4'd5};
            3'd2:    line_cells = {4'd6, 4'd7, 4'd8};
            3'd3:    line_cells = {4'd0, 4'd3, 4'd6};
            3'd4:    line_cells = {4'd1, 4'd4, 4'd7};
            3'd5:    line_cells = {4'd2, 4'd5, 4'd8};
            3'd6:    line_cells = {4'd0, 4'd4, 4'd8};
            3'd7:    line_cells = {4'd2, 4'd4, 4'd6};
            default: line_cells = {4'd0, 4'd1, 4'd2};
        endcase
    endfunction

    logic [1:0]  state_r;
    logic [17:0] board_r;
    logic        player_turn_r;
    logic        busy_r;
    logic        illegal_r;
    logic        game_over_r;
    logic [1:0]  winner_r;
    logic [2:0]  win_line_r;
    logic [3:0]  move_count_r;
    logic [2:0]  line_idx_r;

    logic [1:0]  mark_s;
    logic        sel_ok_s;
    logic [11:0] cells_s;
    logic        line_hit_s;
    logic [17:0] new_board_s;

    // Mover's mark, move legality, candidate board and current line match.
    always_comb begin
        mark_s      = player_turn_r ? MARK_O : MARK_X;
        sel_ok_s    = (bus.square_sel <= 4'd8) &&
                      (cell_at(board_r, bus.square_sel) == MARK_NONE);
        cells_s     = line_cells(line_idx_r);
        line_hit_s  = (cell_at(board_r, cells_s[11:8]) == mark_s) &&
                      (cell_at(board_r, cells_s[7:4])  == mark_s) &&
                      (cell_at(board_r, cells_s[3:0])  == mark_s);
        new_board_s = board_r;
        for (int i = 0; i < 9; i++) begin
            new_board_s[2*i +: 2] = (bus.square_sel == 4'(i)) ? mark_s : board_r[2*i +: 2];
        end
    end

    // Game FSM and all registered status; new_game outranks a same-cycle place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_PLAY;
            board_r       <= 18'd0;
            player_turn_r <= 1'b0;
            busy_r        <= 1'b0;
            illegal_r     <= 1'b0;
            game_over_r   <= 1'b0;
            winner_r      <= MARK_NONE;
            win_line_r    <= 3'd0;
            move_count_r  <= 4'd0;
            line_idx_r    <= 3'd0;
        end else if (bus.new_game) begin
            state_r       <= ST_PLAY;
            board_r       <= 18'd0;
            player_turn_r <= 1'b0;
            busy_r        <= 1'b0;
            illegal_r     <= 1'b0;
            game_over_r   <= 1'b0;
            winner_r      <= MARK_NONE;
            win_line_r    <= 3'd0;
            move_count_r  <= 4'd0;
            line_idx_r    <= 3'd0;
        end else begin
            illegal_r <= 1'b0;
            case (state_r)
                ST_PLAY: begin
                    if (bus.place) begin
                        if (sel_ok_s) begin
                            board_r      <= new_board_s;
                            move_count_r <= move_count_r + 4'd1;
                            line_idx_r   <= 3'd0;
                            busy_r       <= 1'b1;
                            state_r      <= ST_CHECK;
                        end else begin
                            illegal_r    <= 1'b1;
                        end
                    end
                end
                ST_CHECK: begin
                    if (line_hit_s) begin
                        winner_r    <= mark_s;
                        win_line_r  <= line_idx_r;
                        game_over_r <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= ST_WIN;
                    end else if (line_idx_r == 3'd7) begin
                        busy_r <= 1'b0;
                        if (move_count_r == 4'd9) begin
                            game_over_r <= 1'b1;
                            state_r     <= ST_DRAW;
                        end else begin
                            player_turn_r <= ~player_turn_r;
                            state_r       <= ST_PLAY;
                        end
                    end else begin
                        line_idx_r <= line_idx_r + 3'd1;
                    end
                end
                ST_WIN:  state_r <= ST_WIN;
                ST_DRAW: state_r <= ST_DRAW;
                default: state_r <= ST_PLAY;
            endcase
        end
    end

    assign bus.board       = board_r;
    assign bus.player_turn = player_turn_r;
    assign bus.busy        = busy_r;
    assign bus.illegal     = illegal_r;
    assign bus.game_over   = game_over_r;
    assign bus.winner      = winner_r;
    assign bus.win_line    = win_line_r;
    assign bus.move_count  = move_count_r;
endmodule

// File: tb/tb_ttt_game_state.sv
// Scoreboard bench for ttt_game_state: directed games, illegal moves,
// busy collisions, restart and mid-scan reset.
module tb_ttt_game_state;
    logic clk;
    logic rst_n;
    logic probe;

    ttt_game_state_if bus();

    ttt_game_state dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [1:0] K_PROBE = 2'd0;
    localparam logic [1:0] K_SCAN  = 2'd1;
    localparam logic [1:0] K_ILL   = 2'd2;

    typedef struct packed {
        logic [1:0]  kind;
        logic [17:0] board;
        logic        turn;
        logic        busy;
        logic        go;
        logic [1:0]  winner;
        logic [2:0]  wl;
        logic [3:0]  cnt;
        logic [3:0]  cyc;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    logic [17:0] m_board;
    logic        m_turn;
    logic [3:0]  m_count;

    task automatic push(input logic [1:0] kind, input logic [17:0] b, input logic t,
                        input logic go, input logic [1:0] w, input logic [2:0] wl,
                        input logic [3:0] cnt, input logic [3:0] cyc);
        exp_t e;
        e.kind = kind; e.board = b; e.turn = t; e.busy = 1'b0; e.go = go;
        e.winner = w; e.wl = wl; e.cnt = cnt; e.cyc = cyc;
        sb.push_back(e);
    endtask

    // Monitor: an event is an illegal pulse, a falling busy, or a bench probe.
    logic       prev_busy = 1'b0;
    logic       prev_ill  = 1'b0;
    logic [3:0] busy_cnt  = 4'd0;
    int         evt_n     = 0;

    always @(posedge clk) begin
        exp_t act;
        exp_t e;
        logic ev;
        #2;
        if (bus.busy) busy_cnt = busy_cnt + 4'd1;
        ev = 1'b1;
        if (bus.illegal)                  act.kind = K_ILL;
        else if (prev_busy && !bus.busy)  act.kind = K_SCAN;
        else if (probe)                   act.kind = K_PROBE;
        else                              ev = 1'b0;
        if (bus.illegal) begin
            checks++;
            if (prev_ill) begin
                failures++;
                $display("FAIL illegal_width actual=2+cycles required=1cycle");
            end
        end
        if (ev) begin
            act.board = bus.board; act.turn = bus.player_turn; act.busy = bus.busy;
            act.go = bus.game_over; act.winner = bus.winner; act.wl = bus.win_line;
            act.cnt = bus.move_count;
            act.cyc = (act.kind == K_SCAN) ? busy_cnt : 4'd0;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL evt%0d unexpected actual=%h required=none", evt_n, act);
            end else begin
                e = sb.pop_front();
                if (act !== e) begin
                    failures++;
                    $display("FAIL evt%0d actual=%h required=%h", evt_n, act, e);
                end
            end
            evt_n++;
        end
        if (!bus.busy) busy_cnt = 4'd0;
        prev_busy = bus.busy;
        prev_ill  = bus.illegal;
    end

    task automatic pulse_place(input logic [3:0] sel);
        @(negedge clk); bus.square_sel = sel; bus.place = 1'b1;
        @(negedge clk); bus.place = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (bus.busy) begin
            checks++;
            failures++;
            $display("FAIL idle_timeout busy=%0b required=0", bus.busy);
        end
    endtask

    task automatic model_clear();
        m_board = 18'd0; m_turn = 1'b0; m_count = 4'd0;
    endtask

    task automatic new_game();
        @(negedge clk); bus.new_game = 1'b1;
        @(negedge clk); bus.new_game = 1'b0;
        model_clear();
    endtask

    // Non-winning move: mark written, turn toggles, full 8-line scan.
    task automatic move(input logic [3:0] sel);
        m_board[2*sel +: 2] = m_turn ? 2'b10 : 2'b01;
        m_count = m_count + 4'd1;
        m_turn  = ~m_turn;
        push(K_SCAN, m_board, m_turn, 1'b0, 2'b00, 3'd0, m_count, 4'd8);
        pulse_place(sel);
        wait_idle();
    endtask

    task automatic final_move(input logic [3:0] sel, input logic [17:0] b, input logic t,
                              input logic [1:0] w, input logic [2:0] wl,
                              input logic [3:0] cnt, input logic [3:0] cyc);
        push(K_SCAN, b, t, 1'b1, w, wl, cnt, cyc);
        pulse_place(sel);
        wait_idle();
    endtask

    task automatic do_probe(input logic [17:0] b, input logic t, input logic go,
                            input logic [1:0] w, input logic [2:0] wl, input logic [3:0] cnt);
        push(K_PROBE, b, t, go, w, wl, cnt, 4'd0);
        @(negedge clk); probe = 1'b1;
        @(negedge clk); probe = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; probe = 1'b0;
        bus.square_sel = 4'd0; bus.place = 1'b0; bus.new_game = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        do_probe(18'd0, 1'b0, 1'b0, 2'b00, 3'd0, 4'd0);
        @(negedge clk); rst_n = 1'b1;

        // X wins row 0 on the first scanned line.
        move(4'd0); move(4'd3); move(4'd1); move(4'd4);
        final_move(4'd2, 18'h00295, 1'b0, 2'b01, 3'd0, 4'd5, 4'd1);

        // O wins the anti-diagonal on the last scanned line.
        new_game();
        move(4'd0); move(4'd2); move(4'd1); move(4'd4); move(4'd8);
        final_move(4'd6, 18'h12225, 1'b1, 2'b10, 3'd7, 4'd6, 4'd8);

        // Draw, then places in the terminal state are ignored without illegal.
        new_game();
        move(4'd0); move(4'd1); move(4'd2); move(4'd4);
        move(4'd3); move(4'd5); move(4'd7); move(4'd6);
        final_move(4'd8, 18'h16A59, 1'b0, 2'b00, 3'd0, 4'd9, 4'd8);
        pulse_place(4'd0);
        pulse_place(4'd9);
        do_probe(18'h16A59, 1'b0, 1'b1, 2'b00, 3'd0, 4'd9);

        // Occupied cell and out-of-range selector.
        new_game();
        move(4'd0);
        push(K_ILL, 18'h00001, 1'b1, 1'b0, 2'b00, 3'd0, 4'd1, 4'd0);
        pulse_place(4'd0);
        push(K_ILL, 18'h00001, 1'b1, 1'b0, 2'b00, 3'd0, 4'd1, 4'd0);
        pulse_place(4'd12);
        do_probe(18'h00001, 1'b1, 1'b0, 2'b00, 3'd0, 4'd1);

        // Second place on the cycle after an accepted one is dropped.
        new_game();
        push(K_SCAN, 18'h00100, 1'b1, 1'b0, 2'b00, 3'd0, 4'd1, 4'd8);
        @(negedge clk); bus.square_sel = 4'd4; bus.place = 1'b1;
        @(negedge clk); bus.square_sel = 4'd0; bus.place = 1'b1;
        @(negedge clk); bus.place = 1'b0;
        wait_idle();

        // new_game with a simultaneous place during CHECK.
        new_game();
        @(negedge clk); bus.square_sel = 4'd0; bus.place = 1'b1;
        @(negedge clk); bus.place = 1'b0;
        push(K_SCAN, 18'd0, 1'b0, 1'b0, 2'b00, 3'd0, 4'd0, 4'd2);
        @(negedge clk); bus.new_game = 1'b1; bus.place = 1'b1; bus.square_sel = 4'd5;
        @(negedge clk); bus.new_game = 1'b0; bus.place = 1'b0;

        // Asynchronous reset mid-CHECK.
        @(negedge clk); bus.square_sel = 4'd0; bus.place = 1'b1;
        @(negedge clk); bus.place = 1'b0;
        push(K_SCAN, 18'd0, 1'b0, 1'b0, 2'b00, 3'd0, 4'd0, 4'd1);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        do_probe(18'd0, 1'b0, 1'b0, 2'b00, 3'd0, 4'd0);
        @(negedge clk); rst_n = 1'b1;
        model_clear();
        move(4'd4);

        repeat (4) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain pending=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
